// File: rtl/if_stage_fq_pkg.sv
// Shared fetch-stage types: decode-bound bundle layout and
// the address-error exception codes used for misaligned fetch.
package if_stage_fq_pkg;

    localparam int ECODE_WD        = 6;
    localparam int ESUBCODE_WD     = 9;
    localparam int FS_TO_DS_BUS_WD = 1 + ECODE_WD + ESUBCODE_WD + 64;

    localparam logic [ECODE_WD-1:0]    ECODE_ADE     = 6'h08;
    localparam logic [ESUBCODE_WD-1:0] ESUBCODE_ADEF = 9'h000;

    typedef struct packed {
        logic                   ex;
        logic [ECODE_WD-1:0]    ecode;
        logic [ESUBCODE_WD-1:0] esubcode;
        logic [31:0]            inst;
        logic [31:0]            pc;
    } fs_to_ds_t;

    function automatic fs_to_ds_t fs_entry(
        input logic        ex,
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        fs_to_ds_t e;
        e.ex       = ex;
        e.ecode    = ex ? ECODE_ADE : '0;
        e.esubcode = ex ? ESUBCODE_ADEF : '0;
        e.inst     = inst;
        e.pc       = pc;
        return e;
    endfunction

endpackage

// File: rtl/if_stage_fq_fetch_fifo.sv
// Small circular FIFO with flush, used for the in-flight PC
// tracker and for the decode-facing fetch queue.
module if_stage_fq_fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLV = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == FULLV);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];

    // A full FIFO may still accept a push when it pops the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (do_push) wr_d = nxt(wr_q);
        if (do_pop)  rd_d = nxt(rd_q);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/if_stage_fq.sv
// Instruction-fetch front end: pipelined inst_sram requests,
// stale-response discard on redirect, and a fetch queue to decode.
module if_stage_fq
    import if_stage_fq_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IQ_DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       br_stall,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [31:0]                inst_sram_addr,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(IQ_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          halt_q, halt_d;

    logic [OW-1:0] outstanding;
    logic [31:0]   pf_pc;
    logic          pf_full, pf_empty;

    fs_to_ds_t     q_din;
    logic          q_push, q_pop, q_full, q_empty;
    logic [QW-1:0] q_count;

    logic credit_ok, accept, exc;

    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                       (int'(outstanding) + int'(q_count) < IQ_DEPTH);

    assign inst_sram_req = !reset && !redirect_valid && !br_stall &&
                           !halt_q && credit_ok && (pc_q[1:0] == 2'b00);

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = {pc_q[31:2], 2'b00};
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign accept = inst_sram_req && inst_sram_addr_ok;

    assign exc = !halt_q && (pc_q[1:0] != 2'b00) && !redirect_valid &&
                 (outstanding == '0) && !q_full;

    assign q_push = !redirect_valid &&
                    ((inst_sram_data_ok && discard_q == '0) || exc);
    assign q_din  = exc ? fs_entry(1'b1, 32'h0, pc_q)
                        : fs_entry(1'b0, inst_sram_rdata, pf_pc);

    assign fs_to_ds_valid = !reset && !q_empty && !redirect_valid;
    assign q_pop          = fs_to_ds_valid && ds_allowin;

    // Everything still in flight after a redirect is stale; this
    // already covers any responses previously marked for discard.
    always_comb begin
        discard_d = discard_q;
        if (redirect_valid) begin
            if (inst_sram_data_ok && outstanding != '0)
                discard_d = outstanding - OW'(1);
            else
                discard_d = outstanding;
        end else if (inst_sram_data_ok && discard_q != '0) begin
            discard_d = discard_q - OW'(1);
        end
    end

    always_comb begin
        pc_d   = pc_q;
        halt_d = halt_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            halt_d = 1'b0;
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (exc)    halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
            halt_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
            halt_q    <= halt_d;
        end
    end

    if_stage_fq_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .din_i   (pc_q),
        .pop_i   (inst_sram_data_ok),
        .flush_i (1'b0),
        .dout_o  (pf_pc),
        .full_o  (pf_full),
        .empty_o (pf_empty),
        .count_o (outstanding)
    );

    if_stage_fq_fetch_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (IQ_DEPTH)
    ) u_fetch_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (q_push),
        .din_i   (q_din),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .dout_o  (fs_to_ds_bus),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    a_q_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_push && q_full && !q_pop));
    a_pf_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_data_ok && pf_empty));
    a_pf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(accept && pf_full && !inst_sram_data_ok));

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: queue-level reference model, SRAM
// responder, directed scenarios and a randomized run.
module tb_if_stage_fq;
    import if_stage_fq_pkg::*;

    localparam logic [31:0] RPC = 32'h1c000000;
    localparam int MO = 2;
    localparam int IQ = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        br_stall;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    always #5 clk = ~clk;

    if_stage_fq #(
        .RESET_PC        (RPC),
        .MAX_OUTSTANDING (MO),
        .IQ_DEPTH        (IQ)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .br_stall          (br_stall),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;

    // Model: fetch pc, halt flag, in-flight {stale,pc}, queue contents.
    logic [31:0] m_pc;
    logic        m_halt;
    logic [32:0] infl[$];
    logic [79:0] mq[$];
    logic [31:0] sram_q[$];
    logic [31:0] log_pc[$];
    int          log_cyc[$];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lpc(input int i);
        return (log_pc.size() > i) ? log_pc[i] : 32'hdeadbeef;
    endfunction

    function automatic int lcyc(input int i);
        return (log_cyc.size() > i) ? log_cyc[i] : -100;
    endfunction

    task automatic step(input logic rv, input logic [31:0] rpc,
                        input logic bs, input logic da,
                        input logic aok, input logic dk);
        logic        dok, e_req, e_vld, exc, ac;
        logic [31:0] rd;
        logic [32:0] h;
        dok = dk && !reset && (sram_q.size() > 0);
        rd  = dok ? sram_q[0] : $urandom;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        br_stall          = bs;
        ds_allowin        = da;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        #1;
        e_req = !reset && !rv && !bs && !m_halt && (m_pc[1:0] == 2'b00) &&
                (infl.size() < MO) && (infl.size() + mq.size() < IQ);
        e_vld = !reset && !rv && (mq.size() > 0);
        exc   = !m_halt && (m_pc[1:0] != 2'b00) && !rv &&
                (infl.size() == 0) && (mq.size() < IQ);
        chk("req", 80'(inst_sram_req), 80'(e_req));
        if (e_req && inst_sram_req)
            chk("addr", 80'(inst_sram_addr), 80'(m_pc));
        chk("valid", 80'(fs_to_ds_valid), 80'(e_vld));
        if (e_vld && fs_to_ds_valid)
            chk("bus", fs_to_ds_bus, mq[0]);
        chk("const", 80'({inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                          inst_sram_wdata}), 80'({1'b0, 2'b10, 4'h0, 32'h0}));
        if (fs_to_ds_valid && da) begin
            log_pc.push_back(fs_to_ds_bus[31:0]);
            log_cyc.push_back(cyc);
        end
        ac = inst_sram_req && aok;
        if (ac) acc_cnt++;
        if (dok) void'(sram_q.pop_front());
        if (ac) sram_q.push_back($urandom);
        if (reset) begin
            m_pc   = RPC;
            m_halt = 1'b0;
            infl.delete();
            mq.delete();
            sram_q.delete();
        end else begin
            if (e_vld && da) void'(mq.pop_front());
            if (dok && infl.size() > 0) begin
                h = infl.pop_front();
                if (!rv && !h[32])
                    mq.push_back({1'b0, 6'h0, 9'h0, rd, h[31:0]});
            end
            if (rv) begin
                mq.delete();
                foreach (infl[i]) infl[i][32] = 1'b1;
                m_pc   = rpc;
                m_halt = 1'b0;
            end else begin
                if (exc) begin
                    mq.push_back({1'b1, ECODE_ADE, ESUBCODE_ADEF, 32'h0, m_pc});
                    m_halt = 1'b1;
                end
                if (e_req && aok) begin
                    infl.push_back({1'b0, m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("rst_req", 80'(inst_sram_req), 80'(0));
        chk("rst_valid", 80'(fs_to_ds_valid), 80'(0));
        reset = 1'b0;
        log_pc.delete();
        log_cyc.delete();
        acc_cnt = 0;
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        br_stall = 1'b0;
        ds_allowin = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'h0;
        m_pc = RPC;
        m_halt = 1'b0;
        @(negedge clk);

        // streaming at one instruction per cycle
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t1_pc0", 80'(lpc(0)), 80'(32'h1c000000));
        chk("t1_pc1", 80'(lpc(1)), 80'(32'h1c000004));
        chk("t1_pc2", 80'(lpc(2)), 80'(32'h1c000008));
        chk("t1_rate", 80'(lcyc(2) - lcyc(0)), 80'(2));

        // decode stalled: queue fills to four, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_accepts", 80'(acc_cnt), 80'(4));
        chk("t2_req_off", 80'(inst_sram_req), 80'(0));
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t2_pc0", 80'(lpc(0)), 80'(32'h1c000000));
        chk("t2_pc3", 80'(lpc(3)), 80'(32'h1c00000c));
        chk("t2_rate", 80'(lcyc(3) - lcyc(0)), 80'(3));

        // redirect with two outstanding and no data_ok
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h1c000100, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t3_first", 80'(lpc(0)), 80'(32'h1c000100));

        // redirect coinciding with a data_ok beat
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h1c000100, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_first", 80'(lpc(0)), 80'(32'h1c000100));
        chk("t4_second", 80'(lpc(1)), 80'(32'h1c000104));

        // misaligned redirect raises ADEF and halts fetch
        do_reset();
        step(1'b1, 32'h1c000102, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_req_off", 80'(inst_sram_req), 80'(0));
        chk("t5_valid", 80'(fs_to_ds_valid), 80'(1));
        chk("t5_bus", fs_to_ds_bus, {1'b1, 6'h08, 9'h000, 32'h0, 32'h1c000102});
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_popped", 80'(lpc(0)), 80'(32'h1c000102));
        chk("t5_halted", 80'(inst_sram_req), 80'(0));
        step(1'b1, 32'h1c000300, 1'b0, 1'b1, 1'b1, 1'b1);
        redirect_valid = 1'b0;
        #1;
        chk("t5_resume_req", 80'(inst_sram_req), 80'(1));
        chk("t5_resume_addr", 80'(inst_sram_addr), 80'(32'h1c000300));
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        // br_stall with one response pending
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_accepts", 80'(acc_cnt), 80'(1));
        chk("t6_delivered", 80'(lpc(0)), 80'(32'h1c000000));
        br_stall = 1'b0;
        #1;
        chk("t6_resume_req", 80'(inst_sram_req), 80'(1));
        chk("t6_resume_addr", 80'(inst_sram_addr), 80'(32'h1c000004));
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rpc = 32'h1c000000 + ($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 29) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 19) == 0, rpc,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
